// File: rtl/mux_port_arbiter.sv
// Two-requester round-robin burst arbiter driving a shared 32-bit mux2to1.
// Bursts of 1..4 beats, valid/ready downstream, stalled grants time out.

module mux2to1 #(
  parameter int WIDTH = 32
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);
  assign out = sel ? in1 : in0;
endmodule

module mux_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       len0,
  input  logic [1:0]       len1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             out_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             ack0,
  output logic             ack1,
  output logic             busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } state_t;

  state_t        state;
  logic          prio;
  logic [2:0]    beat_cnt;
  logic [TW-1:0] to_cnt;

  logic       own;
  logic       granted;
  logic       req_own;
  logic       req_oth;
  logic [1:0] len_own;
  logic [1:0] len_oth;
  logic       accept;

  assign own     = (state == GNT1);
  assign granted = (state != IDLE);
  assign req_own = own ? req1 : req0;
  assign req_oth = own ? req0 : req1;
  assign len_own = own ? len1 : len0;
  assign len_oth = own ? len0 : len1;

  assign out_valid = granted & req_own;
  assign accept    = out_valid & out_ready;
  assign ack0      = accept & (state == GNT0);
  assign ack1      = accept & (state == GNT1);
  assign busy      = granted;

  mux2to1 #(.WIDTH(WIDTH)) u_mux (
    .sel (sel),
    .in0 (data0),
    .in1 (data1),
    .out (out_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sel      <= 1'b0;
      prio     <= 1'b0;
      beat_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 && (!req1 || !prio)) begin
            state    <= GNT0;
            sel      <= 1'b0;
            beat_cnt <= {1'b0, len0} + 3'd1;
            to_cnt   <= '0;
          end else if (req1) begin
            state    <= GNT1;
            sel      <= 1'b1;
            beat_cnt <= {1'b0, len1} + 3'd1;
            to_cnt   <= '0;
          end
        end
        GNT0, GNT1: begin
          if (accept) begin
            to_cnt <= '0;
            if (beat_cnt == 3'd1) begin
              // burst done: hand over without a bubble if the other side waits
              prio <= ~own;
              if (req_oth) begin
                state    <= own ? GNT0 : GNT1;
                sel      <= ~own;
                beat_cnt <= {1'b0, len_oth} + 3'd1;
              end else begin
                beat_cnt <= {1'b0, len_own} + 3'd1;
              end
            end else begin
              beat_cnt <= beat_cnt - 3'd1;
            end
          end else if (!req_own) begin
            if (to_cnt == TO_LAST) begin
              state  <= IDLE;
              prio   <= ~own;
              to_cnt <= '0;
            end else begin
              to_cnt <= to_cnt + TW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_port_arbiter.sv
// Self-checking bench for mux_port_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.

module tb_mux_port_arbiter;

  localparam int W  = 32;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1;
  logic [1:0]   len0, len1;
  logic [W-1:0] data0, data1;
  logic         out_ready;
  logic         sel, out_valid, ack0, ack1, busy;
  logic [W-1:0] out_data;

  int vectors = 0;
  int miscompares = 0;

  // reference model: owner (-1 = nobody), beats left, idle count
  int   m_own;
  int   m_rem;
  int   m_idle;
  logic m_prio;
  logic m_sel;

  mux_port_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .len0      (len0),
    .len1      (len1),
    .data0     (data0),
    .data1     (data1),
    .out_ready (out_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .ack0      (ack0),
    .ack1      (ack1),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic e_valid();
    if (m_own == 0) return req0;
    if (m_own == 1) return req1;
    return 1'b0;
  endfunction

  task automatic grant(input int k);
    m_own  = k;
    m_rem  = (k == 1) ? int'(len1) + 1 : int'(len0) + 1;
    m_idle = 0;
    m_sel  = (k == 1);
  endtask

  task automatic model_update();
    logic r;
    int   n;
    if (reset) begin
      m_own = -1; m_rem = 0; m_idle = 0;
      m_prio = 1'b0; m_sel = 1'b0;
    end else if (m_own < 0) begin
      if (req0 && req1) grant(m_prio ? 1 : 0);
      else if (req0) grant(0);
      else if (req1) grant(1);
    end else begin
      n = m_own;
      r = (n == 1) ? req1 : req0;
      if (r && out_ready) begin
        m_idle = 0;
        if (m_rem == 1) begin
          m_prio = (n == 0);
          if ((n == 0) ? req1 : req0) grant(1 - n);
          else grant(n);
        end else begin
          m_rem = m_rem - 1;
        end
      end else if (!r) begin
        if (m_idle == TO - 1) begin
          m_own  = -1;
          m_prio = (n == 0);
          m_idle = 0;
        end else begin
          m_idle = m_idle + 1;
        end
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    len0 = 2'd0; len1 = 2'd0;
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    len0 = 2'd0; len1 = 2'd0;
    out_ready = 1'b1;
    data0 = 32'h1; data1 = 32'h2;
    tick();
    tick();
    settle();
    vectors++;
    if ({sel, busy, out_valid, ack0, ack1} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outs: got %b want 00000",
               {sel, busy, out_valid, ack0, ack1});
    end
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_single_burst();
    logic [W-1:0] a [3];
    apply_reset();
    a[0] = 32'hA0A0_0000; a[1] = 32'hA1A1_1111; a[2] = 32'hA2A2_2222;
    req0 = 1'b1; len0 = 2'd2; out_ready = 1'b1; data0 = a[0];
    settle();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL burst_lat: got valid %b want 0", out_valid);
    end
    tick();
    for (int b = 0; b < 3; b++) begin
      data0 = a[b];
      settle();
      vectors++;
      if ({ack0, ack1, sel} !== 3'b100 || out_data !== a[b]) begin
        miscompares++;
        $display("FAIL burst_beat%0d: got ack0/ack1/sel %b data %h want 100 %h",
                 b, {ack0, ack1, sel}, out_data, a[b]);
      end
      tick();
    end
    req0 = 1'b0;
    for (int i = 0; i < TO + 2; i++) begin
      settle();
      vectors++;
      if (busy !== (m_own >= 0)) begin
        miscompares++;
        $display("FAIL burst_tail%0d: got busy %b want %b", i, busy, m_own >= 0);
      end
      tick();
    end
    settle();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL burst_idle: got busy %b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    req0 = 1'b1; req1 = 1'b1; len0 = 2'd0; len1 = 2'd0;
    out_ready = 1'b1;
    data0 = 32'h0000_D000; data1 = 32'h1111_D111;
    tick();
    for (int i = 0; i < 8; i++) begin
      settle();
      vectors++;
      if (ack0 !== (i % 2 == 0) || ack1 !== (i % 2 == 1) || sel !== (i % 2 == 1)) begin
        miscompares++;
        $display("FAIL alt%0d: got ack0 %b ack1 %b sel %b want %b %b %b",
                 i, ack0, ack1, sel, i % 2 == 0, i % 2 == 1, i % 2 == 1);
      end
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_stall();
    int acks;
    logic [5:0] rdy;
    apply_reset();
    rdy = 6'b111001;
    acks = 0;
    req1 = 1'b1; len1 = 2'd3; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      out_ready = rdy[i];
      data1 = $urandom;
      settle();
      vectors++;
      if (out_valid !== 1'b1 || ack1 !== rdy[i] || out_data !== data1) begin
        miscompares++;
        $display("FAIL stall%0d: got valid %b ack1 %b data %h want 1 %b %h",
                 i, out_valid, ack1, out_data, rdy[i], data1);
      end
      if (ack1) acks++;
      tick();
    end
    vectors++;
    if (acks != 4) begin
      miscompares++;
      $display("FAIL stall_count: got %0d ack1 want 4", acks);
    end
    req1 = 1'b0;
  endtask

  task automatic test_timeout();
    apply_reset();
    req0 = 1'b1; len0 = 2'd3; len1 = 2'd0; out_ready = 1'b1;
    tick();
    settle();
    vectors++;
    if (ack0 !== 1'b1) begin
      miscompares++;
      $display("FAIL to_first: got ack0 %b want 1", ack0);
    end
    tick();
    req0 = 1'b0; req1 = 1'b1;
    for (int i = 0; i < TO; i++) begin
      settle();
      vectors++;
      if ({busy, sel, out_valid, ack1} !== 4'b1000) begin
        miscompares++;
        $display("FAIL to_hold%0d: got busy/sel/valid/ack1 %b want 1000",
                 i, {busy, sel, out_valid, ack1});
      end
      tick();
    end
    req0 = 1'b1;
    settle();
    vectors++;
    if ({busy, sel} !== 2'b00) begin
      miscompares++;
      $display("FAIL to_idle: got busy/sel %b want 00", {busy, sel});
    end
    tick();
    settle();
    vectors++;
    if ({sel, ack1, ack0} !== 3'b110) begin
      miscompares++;
      $display("FAIL to_prio1: got sel/ack1/ack0 %b want 110", {sel, ack1, ack0});
    end
    tick();
    settle();
    vectors++;
    if ({sel, ack1, ack0} !== 3'b001) begin
      miscompares++;
      $display("FAIL to_prio0: got sel/ack1/ack0 %b want 001", {sel, ack1, ack0});
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req1 = 1'b1; len1 = 2'd3; out_ready = 1'b1;
    tick();
    tick();
    req0 = 1'b1;
    reset = 1'b1;
    tick();
    settle();
    vectors++;
    if ({sel, busy, out_valid, ack0, ack1} !== 5'b0) begin
      miscompares++;
      $display("FAIL rstmid: got %b want 00000", {sel, busy, out_valid, ack0, ack1});
    end
    reset = 1'b0;
    tick();
    settle();
    vectors++;
    if ({sel, ack0, ack1} !== 3'b010) begin
      miscompares++;
      $display("FAIL rstmid_win: got sel/ack0/ack1 %b want 010", {sel, ack0, ack1});
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_len_change();
    int acks;
    apply_reset();
    acks = 0;
    req1 = 1'b1; len1 = 2'd3; out_ready = 1'b1;
    tick();
    len1 = 2'd0;
    for (int i = 0; i < 4; i++) begin
      settle();
      if (ack1) acks++;
      tick();
    end
    vectors++;
    if (acks != 4) begin
      miscompares++;
      $display("FAIL lenchg: got %0d ack1 want 4", acks);
    end
    req1 = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 79) == 0);
      req0      = ($urandom_range(0, 3) != 0);
      req1      = ($urandom_range(0, 3) != 0);
      if (i % 97 > 70) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      len0      = 2'($urandom);
      len1      = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      data0     = $urandom;
      data1     = $urandom;
      settle();
      vectors++;
      if (out_valid !== e_valid() || sel !== m_sel || busy !== (m_own >= 0) ||
          out_data !== (m_sel ? data1 : data0)) begin
        miscompares++;
        $display("FAIL rnd%0d: got valid %b sel %b busy %b data %h want %b %b %b %h",
                 i, out_valid, sel, busy, out_data, e_valid(), m_sel, m_own >= 0,
                 m_sel ? data1 : data0);
      end
      vectors++;
      if (ack0 !== (e_valid() && out_ready && m_own == 0) ||
          ack1 !== (e_valid() && out_ready && m_own == 1)) begin
        miscompares++;
        $display("FAIL rnd_ack%0d: got ack0 %b ack1 %b want %b %b", i, ack0, ack1,
                 e_valid() && out_ready && m_own == 0,
                 e_valid() && out_ready && m_own == 1);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    len0 = 2'd0; len1 = 2'd0;
    data0 = '0; data1 = '0;
    out_ready = 1'b0;
    m_own = -1; m_rem = 0; m_idle = 0;
    m_prio = 1'b0; m_sel = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_len_change();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
